// File: rtl/barrel_rotator_rx_seq.sv
// barrel_rotator_rx_seq
//   Sequential right rotate / logical-shift-right engine. Undoes the 8-bit
//   left barrel shifter one bit per clock. A rotate right by N restores a
//   word that was rotated left by N.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake (ready only in IDLE)
//   in_data, in_amt         word and right-move amount (0..WIDTH-1)
//   in_logical              0 = rotate right, 1 = shift right with zero fill
//   out_valid/out_ready     result handshake (valid only in DONE)
//   out_data                result word; holds the last result while IDLE
//   busy                    high in SHIFT or DONE

// One bit of the working register: load from the request, move one place
// right from its upper neighbour, or hold.
module barrel_rotator_rx_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  input  logic ld_bit,
  input  logic src_bit,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= 1'b0;
    else if (load)  q <= ld_bit;
    else if (shift) q <= src_bit;
  end
endmodule

module barrel_rotator_rx_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_logical,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shr_src;
  logic             accept;
  logic             shift_en;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign shift_en  = (state_q == SHIFT);
  assign out_data  = data_q;

  // Bit shifted into the MSB: the outgoing LSB for rotate, zero for logical.
  assign shr_src = {(mode_q ? 1'b0 : data_q[0]), data_q[WIDTH-1:1]};

  barrel_rotator_rx_lane u_lane [WIDTH-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (shift_en),
    .ld_bit  (in_data),
    .src_bit (shr_src),
    .q       (data_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q <= in_amt;
        mode_q  <= in_logical;
      end else if (shift_en) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_amt == '0) ? DONE : SHIFT;
      // Leaving on count==1 means the last move lands on this same edge.
      SHIFT:   if (count_q == AMT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_barrel_rotator_rx_seq.sv
module tb_barrel_rotator_rx_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [2:0]   in_amt = '0;
  logic         in_logical = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  barrel_rotator_rx_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_logical(in_logical),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: move right by n over a doubled word (rotate) or plain >> (logical).
  function automatic logic [W-1:0] ref_rr(input logic [W-1:0] x, input int n, input logic lg);
    logic [2*W-1:0] t;
    if (lg) return x >> n;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_rl(input logic [W-1:0] x, input int n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  // Driver: one full operation; returns result, latency in cycles after the
  // accept edge, out_valid one cycle after the result accept, and out_data then.
  task automatic run_op(input logic [W-1:0] d, input int a, input logic lg,
                        output logic [W-1:0] res, output int lat,
                        output logic post_valid, output logic [W-1:0] held);
    int k;
    @(negedge clk);
    in_data = d; in_amt = 3'(a); in_logical = lg; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = W'($urandom); in_amt = 3'($urandom); in_logical = 1'($urandom);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    res = out_valid ? out_data : 'x;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    post_valid = out_valid;
    held = out_data;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: rdy/vld/busy/data got %b%b%b %h, want 100 00",
               in_ready, out_valid, busy, out_data);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] dd [7] = '{8'h55, 8'hCC, 8'h01, 8'h01, 8'h80, 8'hFF, 8'hFF};
    int           aa [7] = '{1, 2, 1, 0, 7, 4, 4};
    logic         ll [7] = '{0, 0, 0, 0, 1, 1, 0};
    logic [W-1:0] ee [7] = '{8'hAA, 8'h33, 8'h80, 8'h01, 8'h01, 8'h0F, 8'hFF};
    logic [W-1:0] res, held;
    logic pv;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(dd[i], aa[i], ll[i], res, lat, pv, held);
      checks++;
      if (res !== ee[i]) begin
        errors++; $display("FAIL directed[%0d] data: got %h want %h", i, res, ee[i]);
      end
      checks++;
      if (lat != aa[i]) begin
        errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, aa[i]);
      end
      checks++;
      if (pv !== 1'b0 || held !== ee[i]) begin
        errors++; $display("FAIL directed[%0d] idle hold: valid %b data %h want 0 %h", i, pv, held, ee[i]);
      end
    end
  endtask

  task automatic test_round_trip;
    logic [W-1:0] src [3] = '{8'h55, 8'hCC, 8'h01};
    logic [W-1:0] res, held;
    logic pv;
    int lat;
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < W; a++) begin
        run_op(ref_rl(src[i], a), a, 1'b0, res, lat, pv, held);
        checks++;
        if (res !== src[i]) begin
          errors++; $display("FAIL round_trip %h amt %0d: got %h want %h", src[i], a, res, src[i]);
        end
      end
  endtask

  task automatic test_random;
    logic [W-1:0] d, res, held, exp;
    logic lg, pv;
    int a, lat;
    for (int i = 0; i < 30; i++) begin
      d = W'($urandom); a = $urandom_range(0, W-1); lg = 1'($urandom);
      exp = ref_rr(d, a, lg);
      run_op(d, a, lg, res, lat, pv, held);
      checks++;
      if (res !== exp || lat != a) begin
        errors++;
        $display("FAIL random %h amt %0d lg %b: got %h lat %0d want %h lat %0d", d, a, lg, res, lat, exp, a);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp;
    int k;
    exp = ref_rr(8'hCC, 3, 1'b0);
    @(negedge clk);
    in_data = 8'hCC; in_amt = 3'd3; in_logical = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h12; in_amt = 3'd5; in_logical = 1'b1;  // stays valid to tempt a second accept
    @(negedge clk);
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, out_data, in_ready, busy} !== {1'b1, exp, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL backpressure cyc %0d: vld %b data %h rdy %b busy %b want 1 %h 0 1",
                 i, out_valid, out_data, in_ready, busy, exp);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure release: vld %b rdy %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 10;
    logic [W-1:0] od [N];
    int           oa [N];
    logic         ol [N];
    logic [W-1:0] q_exp [$];
    int           acc [$];
    logic [W-1:0] exp;
    int idx, got;
    logic adv;
    for (int i = 0; i < N; i++) begin
      od[i] = W'($urandom); oa[i] = $urandom_range(0, W-1); ol[i] = 1'($urandom);
    end
    @(negedge clk);
    idx = 0; got = 0;
    in_data = od[0]; in_amt = 3'(oa[0]); in_logical = ol[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 300 && got < N; t++) begin
      if (out_valid) begin
        checks++;
        exp = (q_exp.size() > 0) ? q_exp.pop_front() : 'x;
        if (out_data !== exp) begin
          errors++; $display("FAIL b2b result %0d: got %h want %h", got, out_data, exp);
        end
        got++;
      end
      adv = 1'b0;
      if (in_ready && in_valid) begin
        q_exp.push_back(ref_rr(od[idx], oa[idx], ol[idx]));
        acc.push_back(cyc);
        adv = 1'b1;
      end
      @(posedge clk); #1;
      if (adv) begin
        idx++;
        if (idx < N) begin in_data = od[idx]; in_amt = 3'(oa[idx]); in_logical = ol[idx]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (got != N || q_exp.size() != 0) begin
      errors++; $display("FAIL b2b count: got %0d results pending %0d want %0d 0", got, q_exp.size(), N);
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != oa[i-1] + 2) begin
        errors++; $display("FAIL b2b spacing %0d: got %0d want %0d", i, acc[i] - acc[i-1], oa[i-1] + 2);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    @(negedge clk);
    in_data = 8'h5A; in_amt = 3'd6; in_logical = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_shift: rdy/vld/busy/data got %b%b%b %h want 100 00",
               in_ready, out_valid, busy, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid_shift late result: %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_round_trip;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_shift;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
